// File: rtl/hub_slot.sv
// Round-robin hub access sequencer: one cog transaction per ena_bus cycle, driving the hub_mem port.
// Optional HUB_SLOT_SKIP_EN: skip idle slots and grant the next requesting cog instead of strict rotation.
module hub_slot (
  input  logic         clk_cog,
  input  logic         nres,
  input  logic         ena_bus,
  input  logic [7:0]   req,
  input  logic [7:0]   w,
  input  logic [31:0]  wb,
  input  logic [111:0] a,
  input  logic [255:0] d,
  output logic [7:0]   ack,
  output logic [31:0]  q,
  output logic [2:0]   slot,
  output logic         mem_w,
  output logic [3:0]   mem_wb,
  output logic [13:0]  mem_a,
  output logic [31:0]  mem_d,
  output logic         mem_ena,
  input  logic [31:0]  mem_q
);

  logic [2:0]  busy_cog;
  logic [2:0]  candidate;
  logic [2:0]  sel;
  logic        grant;
  logic [2:0]  slot_next;

  logic [13:0] cog_a  [8];
  logic [3:0]  cog_wb [8];
  logic [31:0] cog_d  [8];

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      cog_a[k]  = a[14*k +: 14];
      cog_wb[k] = wb[4*k +: 4];
      cog_d[k]  = d[32*k +: 32];
    end
  end

`ifdef HUB_SLOT_SKIP_EN
  // First requesting cog at or after the slot pointer, wrapping mod 8; falls back to slot when idle.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    candidate = slot;
    found     = 1'b0;
    idx       = slot;
    for (int i = 0; i < 8; i++) begin
      idx = slot + i[2:0];
      if (!found && req[idx]) begin
        candidate = idx;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    slot_next = grant ? candidate + 3'd1 : slot + 3'd1;
  end
`else
  always_comb begin
    candidate = slot;
  end

  always_comb begin
    slot_next = slot + 3'd1;
  end
`endif

  assign grant = ena_bus & req[candidate];

  // Reset pins the memory port to cog 0 fields so hub_mem sees a stable address while held.
  assign sel     = nres ? candidate : 3'd0;
  assign mem_a   = cog_a[sel];
  assign mem_wb  = cog_wb[sel];
  assign mem_d   = cog_d[sel];
  assign mem_w   = nres & grant & w[sel];
  assign mem_ena = ena_bus;

  // hub_mem registers the read on the grant edge, so its output is already valid in the ack cycle.
  assign q = mem_q;

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      slot     <= 3'd0;
      ack      <= 8'h00;
      busy_cog <= 3'd0;
    end else begin
      ack <= 8'h00;
      if (ena_bus) begin
        slot <= slot_next;
        if (grant) begin
          ack      <= 8'h01 << candidate;
          busy_cog <= candidate;
        end
      end
    end
  end

  ack_matches_busy_cog : assert property (@(posedge clk_cog) disable iff (!nres)
    (ack != 8'h00) |-> (ack == (8'h01 << busy_cog)));

  ack_one_hot : assert property (@(posedge clk_cog) disable iff (!nres) $onehot0(ack));

endmodule

// File: tb/tb_hub_slot.sv
// Self-checking bench for hub_slot with a behavioural hub_mem model (registered read, byte-enable writes).
// Strict-rotation checks run by default; the skip-idle check runs when HUB_SLOT_SKIP_EN is defined.
module tb_hub_slot;

  logic         clk_cog = 1'b0;
  logic         nres;
  logic         ena_bus;
  logic [7:0]   req;
  logic [7:0]   w;
  logic [31:0]  wb;
  logic [111:0] a;
  logic [255:0] d;
  logic [7:0]   ack;
  logic [31:0]  q;
  logic [2:0]   slot;
  logic         mem_w;
  logic [3:0]   mem_wb;
  logic [13:0]  mem_a;
  logic [31:0]  mem_d;
  logic         mem_ena;
  logic [31:0]  mem_q;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] mem [0:16383];
  logic        pl_en = 1'b0;
  logic [13:0] pl_a  = '0;
  logic [31:0] pl_d  = '0;

  hub_slot dut (
    .clk_cog (clk_cog),
    .nres    (nres),
    .ena_bus (ena_bus),
    .req     (req),
    .w       (w),
    .wb      (wb),
    .a       (a),
    .d       (d),
    .ack     (ack),
    .q       (q),
    .slot    (slot),
    .mem_w   (mem_w),
    .mem_wb  (mem_wb),
    .mem_a   (mem_a),
    .mem_d   (mem_d),
    .mem_ena (mem_ena),
    .mem_q   (mem_q)
  );

  always #5 clk_cog = ~clk_cog;

  // Stand-in for hub_mem: read data is registered on the same edge the write lands.
  always @(posedge clk_cog) begin
    if (pl_en) begin
      mem[pl_a] <= pl_d;
    end else if (mem_ena) begin
      for (int b = 0; b < 4; b++)
        if (mem_w && mem_wb[b]) mem[mem_a][8*b +: 8] <= mem_d[8*b +: 8];
      mem_q <= mem[mem_a];
    end
  end

  typedef struct {
    logic        ena;
    logic [7:0]  req;
    logic [7:0]  w;
    logic        exp_memw;
    logic [13:0] exp_mema;
    logic [7:0]  exp_ack;
    logic [2:0]  exp_slot;
  } vec_t;

  vec_t vecs [12];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [7:0] r, input logic [7:0] wr);
    ena_bus = e;
    req     = r;
    w       = wr;
  endtask

  task automatic setCog(input int k, input logic [13:0] addr, input logic [3:0] be, input logic [31:0] data);
    a[14*k +: 14] = addr;
    wb[4*k +: 4]  = be;
    d[32*k +: 32] = data;
  endtask

  task automatic preload(input logic [13:0] addr, input logic [31:0] data);
    @(negedge clk_cog);
    pl_en = 1'b1;
    pl_a  = addr;
    pl_d  = data;
    @(negedge clk_cog);
    pl_en = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk_cog);
    nres = 1'b0;
    @(negedge clk_cog);
    @(negedge clk_cog);
    nres = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk_cog);
    #1;
  endtask

  initial begin
    int  edges;
    bit  found;

    nres = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00);
    a = '0; wb = '0; d = '0;
    for (int k = 0; k < 8; k++) setCog(k, 14'h100 + 14'(k), 4'hF, 32'hC0C0_0000 + 32'(k));

    preload(14'h0010, 32'hDEAD_BEEF);
    preload(14'h0020, 32'h1122_3344);
    #1;
    checkOutput("reset_ack", {24'h0, ack}, 32'h0);
    checkOutput("reset_slot", {29'h0, slot}, 32'h0);
    @(negedge clk_cog);
    nres = 1'b1;

`ifndef HUB_SLOT_SKIP_EN
    //            ena   req    w      memw  mem_a     ack    slot after edge
    vecs[0]  = '{1'b1, 8'h00, 8'h00, 1'b0, 14'h100, 8'h00, 3'd1};
    vecs[1]  = '{1'b0, 8'h02, 8'h02, 1'b0, 14'h101, 8'h00, 3'd1};
    vecs[2]  = '{1'b1, 8'h02, 8'h02, 1'b1, 14'h101, 8'h02, 3'd2};
    vecs[3]  = '{1'b0, 8'h00, 8'h00, 1'b0, 14'h102, 8'h00, 3'd2};
    vecs[4]  = '{1'b1, 8'h08, 8'h00, 1'b0, 14'h102, 8'h00, 3'd3};
    vecs[5]  = '{1'b1, 8'h08, 8'h08, 1'b1, 14'h103, 8'h08, 3'd4};
    vecs[6]  = '{1'b1, 8'h10, 8'h00, 1'b0, 14'h104, 8'h10, 3'd5};
    vecs[7]  = '{1'b1, 8'h20, 8'h20, 1'b1, 14'h105, 8'h20, 3'd6};
    vecs[8]  = '{1'b1, 8'h00, 8'hFF, 1'b0, 14'h106, 8'h00, 3'd7};
    vecs[9]  = '{1'b0, 8'h80, 8'h80, 1'b0, 14'h107, 8'h00, 3'd7};
    vecs[10] = '{1'b1, 8'h80, 8'h00, 1'b0, 14'h107, 8'h80, 3'd0};
    vecs[11] = '{1'b1, 8'h01, 8'h00, 1'b0, 14'h100, 8'h01, 3'd1};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].ena, vecs[i].req, vecs[i].w);
      #1;
      checkOutput($sformatf("vec%0d_mem_w", i), {31'h0, mem_w}, {31'h0, vecs[i].exp_memw});
      checkOutput($sformatf("vec%0d_mem_a", i), {18'h0, mem_a}, {18'h0, vecs[i].exp_mema});
      tick();
      checkOutput($sformatf("vec%0d_ack", i), {24'h0, ack}, {24'h0, vecs[i].exp_ack});
      checkOutput($sformatf("vec%0d_slot", i), {29'h0, slot}, {29'h0, vecs[i].exp_slot});
    end
`endif

    // Reset with a cog 2 ack pending: everything must clear without waiting for a clock edge.
    applyStimulus(1'b1, 8'h04, 8'h00);
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      tick();
      if (ack == 8'h04) found = 1'b1;
    end
    checkOutput("rst_ack_seen", {31'h0, found}, 32'h1);
    applyStimulus(1'b1, 8'hFF, 8'hFF);
    nres = 1'b0;
    #1;
    checkOutput("rst_async_ack", {24'h0, ack}, 32'h0);
    checkOutput("rst_async_slot", {29'h0, slot}, 32'h0);
    checkOutput("rst_async_mem_w", {31'h0, mem_w}, 32'h0);
    checkOutput("rst_mem_a_cog0", {18'h0, mem_a}, 32'h100);
    applyStimulus(1'b0, 8'h00, 8'h00);
    @(negedge clk_cog);
    nres = 1'b1;

`ifndef HUB_SLOT_SKIP_EN
    // Single read by cog 3 with ena_bus every other cycle.
    setCog(3, 14'h0010, 4'hF, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      applyStimulus((i % 2) == 0, 8'h08, 8'h00);
      tick();
      if (ack != 8'h00) begin
        found = 1'b1;
        checkOutput("read_ack", {24'h0, ack}, 32'h08);
        checkOutput("read_q", q, 32'hDEAD_BEEF);
        checkOutput("read_slot_after", {29'h0, slot}, 32'h4);
        checkOutput("read_cycle", i, 6);
      end
    end
    checkOutput("read_ack_seen", {31'h0, found}, 32'h1);
    applyStimulus(1'b0, 8'h00, 8'h00);
    tick();
    checkOutput("read_ack_width", {24'h0, ack}, 32'h0);

    // Byte write by cog 5, then readback exactly one rotation later.
    setCog(5, 14'h0020, 4'b0010, 32'h0000_AB00);
    found = 1'b0;
    applyStimulus(1'b1, 8'h20, 8'h20);
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (ack != 8'h00) begin
        found = 1'b1;
        checkOutput("bw_write_ack", {24'h0, ack}, 32'h20);
      end
    end
    checkOutput("bw_write_seen", {31'h0, found}, 32'h1);
    applyStimulus(1'b1, 8'h20, 8'h00);
    found = 1'b0;
    edges = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      edges++;
      if (ack != 8'h00) begin
        found = 1'b1;
        checkOutput("bw_read_ack", {24'h0, ack}, 32'h20);
        checkOutput("bw_read_q", q, 32'h1122_AB44);
      end
    end
    checkOutput("bw_read_seen", {31'h0, found}, 32'h1);
    checkOutput("bw_ack_spacing", edges, 8);
    applyStimulus(1'b0, 8'h00, 8'h00);

    // All eight cogs at once: acks follow slot order with no repeats.
    doReset();
    for (int k = 0; k < 8; k++) setCog(k, 14'h200 + 14'(k), 4'hF, 32'h0);
    applyStimulus(1'b1, 8'hFF, 8'h00);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput($sformatf("all8_ack%0d", i), {24'h0, ack}, 32'h1 << i);
      req[i] = 1'b0;
    end
    tick();
    checkOutput("all8_no_repeat", {24'h0, ack}, 32'h0);
    checkOutput("all8_wrap_slot", {29'h0, slot}, 32'h1);

    // Late request: cog 2 rises just after its slot passed and waits a full rotation.
    doReset();
    applyStimulus(1'b1, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("late_slot_start", {29'h0, slot}, 32'h3);
    req = 8'h04;
    found = 1'b0;
    edges = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      edges++;
      if (ack != 8'h00) begin
        found = 1'b1;
        checkOutput("late_ack", {24'h0, ack}, 32'h04);
      end
    end
    checkOutput("late_ack_seen", {31'h0, found}, 32'h1);
    checkOutput("late_wait_edges", edges, 8);
    checkOutput("late_slot_after", {29'h0, slot}, 32'h3);
    applyStimulus(1'b0, 8'h00, 8'h00);
`else
    // Skip mode: only cog 6 requesting from slot 0 is granted on the first enabled edge.
    doReset();
    applyStimulus(1'b1, 8'h40, 8'h00);
    #1;
    checkOutput("skip_mem_a", {18'h0, mem_a}, 32'h106);
    tick();
    checkOutput("skip_ack", {24'h0, ack}, 32'h40);
    checkOutput("skip_slot", {29'h0, slot}, 32'h7);
    applyStimulus(1'b1, 8'h00, 8'h00);
    tick();
    checkOutput("skip_idle_ack", {24'h0, ack}, 32'h0);
    checkOutput("skip_idle_slot", {29'h0, slot}, 32'h0);
    applyStimulus(1'b1, 8'h0A, 8'h00);
    tick();
    checkOutput("skip_scan_ack", {24'h0, ack}, 32'h02);
    checkOutput("skip_scan_slot", {29'h0, slot}, 32'h2);
    tick();
    checkOutput("skip_scan2_ack", {24'h0, ack}, 32'h08);
    checkOutput("skip_scan2_slot", {29'h0, slot}, 32'h4);
    applyStimulus(1'b0, 8'h00, 8'h00);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
